// File: rtl/seq_divider32.sv
// seq_divider32: multi-cycle restoring divider for MIPS div/divu, one shift-subtract step per clock
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH:0] pr, t;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] q, dvs, dvd_mag, dvs_mag;
  logic [4:0] cnt;
  logic neg_q, neg_r, ge, unused_pr_msb;
  assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
  assign t = {pr[WIDTH-1:0], q[WIDTH-1]};
  assign sum = {1'b0, t} + {1'b0, ~{1'b0, dvs}} + (WIDTH+2)'(1);
  assign ge = sum[WIDTH+1];
  assign unused_pr_msb = pr[WIDTH];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? DONE : ITER;
      ITER: if (cnt == 5'd31) state_nx = FIX;
      FIX: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pr <= '0;
      q <= '0;
      dvs <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          q <= dvd_mag;
          dvs <= dvs_mag;
          neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r <= is_signed & dividend[WIDTH-1];
          pr <= '0;
          cnt <= '0;
          if (divisor == '0) begin
            quotient <= '1;
            remainder <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        ITER: begin
          pr <= ge ? sum[WIDTH:0] : t;
          q <= {q[WIDTH-2:0], ge};
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          quotient <= neg_q ? -q : q;
          remainder <= neg_r ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32: scoreboard bench for seq_divider32 against an arithmetic reference model
module tb_seq_divider32;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic z;
    int t;
    int lat;
  } exp_t;
  exp_t sb[$];
  seq_divider32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endfunction
  function automatic exp_t model(bit s, logic [31:0] a, logic [31:0] b, int t);
    exp_t e;
    longint x, y;
    e.t = t;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
      e.lat = 1;
    end else begin
      x = s ? longint'($signed(a)) : longint'({32'b0, a});
      y = s ? longint'($signed(b)) : longint'({32'b0, b});
      e.q = 32'(x / y);
      e.r = 32'(x % y);
      e.z = 1'b0;
      e.lat = 34;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
        chk("latency", 32'(cyc - e.t), 32'(e.lat));
      end
    end
  end
  task automatic issue(bit s, logic [31:0] a, logic [31:0] b, bit push);
    @(negedge clk);
    is_signed = s;
    dividend = a;
    divisor = b;
    start = 1'b1;
    if (push) sb.push_back(model(s, a, b, cyc));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask
  task automatic wait_result();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
  endtask
  task automatic run(bit s, logic [31:0] a, logic [31:0] b);
    issue(s, a, b, 1'b1);
    wait_result();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    run(1'b0, 32'd100, 32'd7);
    run(1'b1, -32'sd7, 32'd2);
    run(1'b1, 32'd7, -32'sd2);
    run(1'b1, -32'sd7, -32'sd2);
    run(1'b0, 32'hFFFF_FFFF, 32'd1);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b0, 32'd1234, 32'd0);
    run(1'b1, -32'sd5, 32'd0);
    chk("dir_q_m7_2", sb.size() == 0 ? model(1'b1, -32'sd7, 32'd2, 0).q : 32'hx, 32'hFFFF_FFFD);
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = (k % 8 == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      endcase
      run(1'($urandom_range(0, 1)), a, b);
    end
    issue(1'b0, 32'd1000, 32'd9, 1'b1);
    repeat (8) @(negedge clk);
    is_signed = 1'b1;
    dividend = 32'd55;
    divisor = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result();
    run(1'b0, 32'd55, 32'd5);
    issue(1'b0, 32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    run(1'b0, 32'd100, 32'd7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_divider32.md
# seq_divider32

Multi-cycle 32-bit integer divider for the MIPS `div`/`divu` path. It performs one restoring shift-subtract step per clock through a single trial subtractor, so the whole operation takes 32 iteration cycles. Results are written to HI (remainder) and LO (quotient) by the surrounding datapath. The control FSM schedules the shared subtractor and handles sign pre- and post-processing, divide-by-zero and the start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the only supported value is 32.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `start`  in  1  request a division; accepted only in IDLE.
- `is_signed`  in  1  1 = `div` (two's complement), 0 = `divu`; sampled with `start`.
- `dividend`  in  32  sampled with `start`.
- `divisor`  in  32  sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance until `done`, inclusive.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.
- `quotient`  out  32  registered; goes to LO.
- `remainder`  out  32  registered; goes to HI.
- `div_by_zero`  out  1  registered; set with `done` when the captured divisor was 0.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - On `start`=1, capture the operands and `is_signed`.
  - Compute magnitudes: if signed and the operand is negative, use its two's-complement negation; otherwise use it unchanged.
  - Record `neg_q` = signed & (sign(dividend) ^ sign(divisor)) and `neg_r` = signed & sign(dividend).
  - Clear the partial remainder PR (33 bits) and set count = 0.
  - Go to ITER, or go to DONE directly if divisor == 0.
- ITER, once per cycle:
  - Form T = {PR[31:0], Q[31]} (33 bits), where Q is the working dividend/quotient register.
  - Compute D = T − {1'b0, |divisor|} with one 33-bit subtraction (a + ~b + 1).
  - If D is non-negative (carry-out = 1): PR ← D and Q ← {Q[30:0], 1}.
  - Otherwise: PR ← T and Q ← {Q[30:0], 0}.
  - Increment count. After the count = 31 step, go to FIX.
  - This is the only use of the subtractor; the sign negations in IDLE and FIX use their own incrementers.
- FIX:
  - `quotient` ← neg_q ? −Q : Q.
  - `remainder` ← neg_r ? −PR[31:0] : PR[31:0].
  - `div_by_zero` ← 0. Go to DONE.
- Divide by zero: in the IDLE→DONE transition, `quotient` ← 32'hFFFF_FFFF, `remainder` ← dividend (raw value), `div_by_zero` ← 1.
- DONE: `done` = 1 and `busy` = 1 for exactly one cycle, then go to IDLE.
- Outputs hold their values until the next completed operation.
- Overflow case: signed 0x8000_0000 / 0xFFFF_FFFF yields quotient 0x8000_0000, remainder 0. The magnitude arithmetic wraps naturally; this case gets no special logic and raises no flag.
- `start` outside IDLE is ignored; it is not queued.

## Timing
- Reset (`rst_n`=0 at an edge): state → IDLE; `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder`, PR, Q and count = 0.
- Reset takes priority over `start` and over an operation in flight. Aborting mid-operation leaves no partial result visible.
- Let the acceptance edge be E0:
  - ITER occupies the cycles after edges E0 through E31.
  - FIX follows edge E32; DONE follows edge E33.
  - `done` is high in the cycle after E33, i.e. 34 cycles after acceptance.
- Divide by zero: `done` is high in the cycle after E0 (latency 1).
- Back-to-back operation: `start` may be asserted in the DONE cycle. It is ignored there and must be re-asserted in IDLE, so the minimum issue interval is 35 cycles.
- `busy` = 0 in IDLE only; the pipeline stalls whenever `busy` = 1.

## Test plan
- Unsigned: 100 / 7 → quotient 14, remainder 2, `done` exactly 34 cycles after `start`, `div_by_zero` = 0.
- Signed sign combinations:
  - −7 / 2 → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF.
  - 7 / −2 → quotient 0xFFFF_FFFD, remainder 1.
  - −7 / −2 → quotient 3, remainder 0xFFFF_FFFF.
- Width edges:
  - `divu` 0xFFFF_FFFF / 1 → quotient 0xFFFF_FFFF, remainder 0.
  - `divu` 0xFFFF_FFFF / 0xFFFF_FFFF → quotient 1, remainder 0.
  - `div` 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0.
- Divide by zero: 1234 / 0 → `done` the cycle after the acceptance edge; quotient 0xFFFF_FFFF, remainder 1234, `div_by_zero` = 1.
- Handshake: pulse `start` with new operands at cycle 10 of an operation → ignored; the first result is unchanged. A second `start` in IDLE afterwards is accepted normally.
- Reset mid-operation: drive `rst_n` low at iteration 15 → the next cycle shows `busy` = 0 and all outputs 0. No `done` pulse follows, and a fresh 100 / 7 then completes correctly.
